// File: rtl/gpu_fb_arbiter.sv
// rtl/gpu_fb_arbiter.sv - framebuffer write-port arbiter between CPU bus writes and a fill engine
module gpu_fb_arbiter #(
  parameter int          FB_WORDS       = 15000,
  parameter int          MAX_CPU_STREAK = 8,
  parameter logic [23:0] REG_BASE       = 24'h50004
) (
  input  logic        clk_bus,
  input  logic        rst,
  input  logic [23:0] bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        bus_stall,
  output logic        mem_wren,
  output logic [13:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        fill_busy,
  output logic        fill_done
);

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [31:0]   r_start;
  logic [31:0]   r_count;
  logic [31:0]   r_data;
  logic [14:0]   r_remaining;
  logic [13:0]   r_cur_addr;
  logic [SW-1:0] r_streak;
  logic          r_done_sticky;

  logic          w_run;
  logic          w_fb_wr;
  logic          w_sel_start;
  logic          w_sel_count;
  logic          w_sel_data;
  logic          w_sel_ctrl;
  logic          w_go;
  logic          w_abort;
  logic          w_stall;
  logic          w_cpu_grant;
  logic          w_fill_grant;
  logic          w_fill_last;
  logic          w_done_evt;
  logic [13:0]   w_start_mod;
  logic [13:0]   w_cur_next;

  assign w_run       = (r_state == S_RUN);
  assign w_fb_wr     = bus_write && (bus_address < 24'h50000);
  assign w_sel_start = (bus_address == REG_BASE);
  assign w_sel_count = (bus_address == REG_BASE + 24'd4);
  assign w_sel_data  = (bus_address == REG_BASE + 24'd8);
  assign w_sel_ctrl  = (bus_address == REG_BASE + 24'd12);
  assign w_go        = bus_write && w_sel_ctrl && bus_data_i[0];
  assign w_abort     = bus_write && w_sel_ctrl && bus_data_i[1];

  // The CPU loses exactly one slot once it has won MAX_CPU_STREAK in a row during a fill.
  assign w_stall      = w_run && w_fb_wr && (r_streak == SW'(MAX_CPU_STREAK));
  assign w_cpu_grant  = w_fb_wr && !w_stall;
  assign w_fill_grant = w_run && !w_cpu_grant;
  assign w_fill_last  = w_fill_grant && (r_remaining == 15'd1);
  assign w_done_evt   = (w_run && (w_fill_last || w_abort)) ||
                        (!w_run && w_go && (r_count[14:0] == 15'd0));

  // START only carries 14 bits, so a single conditional subtract gives the modulo.
  assign w_start_mod = (r_start[13:0] >= 14'(FB_WORDS)) ? r_start[13:0] - 14'(FB_WORDS)
                                                          : r_start[13:0];
  assign w_cur_next  = (r_cur_addr == 14'(FB_WORDS - 1)) ? 14'd0 : r_cur_addr + 14'd1;

  assign bus_stall = w_stall;

  // Register readback mux; unmapped addresses read as zero.
  always_comb begin
    bus_data_o = 32'd0;
    if (w_sel_start)      bus_data_o = r_start;
    else if (w_sel_count) bus_data_o = r_count;
    else if (w_sel_data)  bus_data_o = r_data;
    else if (w_sel_ctrl)  bus_data_o = {30'd0, r_done_sticky, fill_busy};
  end

  // Fill FSM, arbitration, register file and the registered memory write port.
  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_start       <= 32'd0;
      r_count       <= 32'd0;
      r_data        <= 32'd0;
      r_remaining   <= 15'd0;
      r_cur_addr    <= 14'd0;
      r_streak      <= '0;
      r_done_sticky <= 1'b0;
      mem_wren      <= 1'b0;
      mem_addr      <= 14'd0;
      mem_data      <= 32'd0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
    end else begin
      fill_done <= w_done_evt;
      mem_wren  <= 1'b0;

      if (w_cpu_grant) begin
        mem_wren <= 1'b1;
        mem_addr <= bus_address[15:2];
        mem_data <= bus_data_i;
      end else if (w_fill_grant) begin
        mem_wren <= 1'b1;
        mem_addr <= r_cur_addr;
        mem_data <= r_data;
      end

      // Set wins over the read-clear so a completion is never lost.
      if (w_done_evt)
        r_done_sticky <= 1'b1;
      else if (bus_read && w_sel_ctrl)
        r_done_sticky <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_streak <= '0;
          if (bus_write && w_sel_start) r_start <= bus_data_i;
          if (bus_write && w_sel_count) r_count <= bus_data_i;
          if (bus_write && w_sel_data)  r_data  <= bus_data_i;
          if (w_go && (r_count[14:0] != 15'd0)) begin
            r_state     <= S_RUN;
            fill_busy   <= 1'b1;
            r_cur_addr  <= w_start_mod;
            r_remaining <= r_count[14:0];
          end
        end
        S_RUN: begin
          if (w_cpu_grant)
            r_streak <= r_streak + SW'(1);
          else
            r_streak <= '0;
          if (w_fill_grant) begin
            r_cur_addr  <= w_cur_next;
            r_remaining <= r_remaining - 15'd1;
          end
          if (w_fill_last || w_abort) begin
            r_state   <= S_IDLE;
            fill_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpu_fb_arbiter.md
Name: gpu_fb_arbiter

Overview:
- Owns the single write port of the GPU framebuffer memory (15000 x 32-bit words, 800x600 at 1 bpp) on the bus clock domain.
- Shares that port between two requesters: CPU bus writes, and a built-in hardware fill engine that clears or fills a word range.
- The CPU programs the fill engine through control registers. CPU writes normally win arbitration; a streak limiter guarantees the fill engine forward progress.

Parameters:
- FB_WORDS, 15000, framebuffer size in words; fill addresses wrap modulo this value.
- MAX_CPU_STREAK, 8, maximum consecutive CPU grants while a fill is pending before the fill engine is forced one slot.
- REG_BASE, 24'h50004, byte address of the first fill register.

Ports:
- clk_bus  in  1  bus clock; all logic is on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- bus_address  in  24  byte address.
- bus_data_i  in  32  write data.
- bus_read  in  1  read strobe.
- bus_write  in  1  write strobe.
- bus_data_o  out  32  read data (combinational).
- bus_stall  out  1  stall request to the CPU (combinational).
- mem_wren  out  1  framebuffer write enable (registered).
- mem_addr  out  14  framebuffer word address (registered).
- mem_data  out  32  framebuffer write data (registered).
- fill_busy  out  1  high while the engine is in RUN.
- fill_done  out  1  one-cycle pulse at fill completion or abort.

Behaviour:
- Decode:
  - FB write: bus_write && bus_address < 24'h50000; word address is bus_address[15:2].
  - Registers (word aligned): START = REG_BASE, COUNT = REG_BASE+4, DATA = REG_BASE+8, CTRL = REG_BASE+12.
  - START, COUNT, DATA are each 32-bit. START uses bits [13:0]; COUNT uses bits [14:0].
  - CTRL write: bit0 = go, bit1 = abort.
- Reads:
  - Address CTRL returns {30'd0, fill_done_sticky, fill_busy}.
  - Other register addresses return their stored value.
  - Any other address returns 0.
  - The CTRL read clears fill_done_sticky on the same edge.
- Reset values: every output 0; START, COUNT, DATA, remaining, cur_addr, streak and fill_done_sticky all 0; state IDLE.
- States: IDLE and RUN.
- IDLE -> RUN:
  - A CTRL write with bit0=1 and COUNT != 0 loads cur_addr = START mod FB_WORDS and remaining = COUNT.
  - fill_busy rises on the next cycle.
- Go with COUNT == 0: stay in IDLE, pulse fill_done next cycle, set the sticky bit.
- Writes to START, COUNT or DATA in RUN are ignored. CTRL go in RUN is ignored.
- Abort (CTRL bit1=1) in RUN:
  - RUN -> IDLE at that edge.
  - A fill write granted in that same cycle is still issued.
  - fill_done pulses in the following cycle; the sticky bit is set.
- Arbitration, evaluated each cycle in RUN:
  - If an FB write is present and streak < MAX_CPU_STREAK: the CPU is granted, streak++, no stall.
  - If an FB write is present and streak == MAX_CPU_STREAK: bus_stall=1, the fill engine is granted, streak resets to 0. The CPU write is held by the bus and granted the next cycle.
  - If no FB write is present: the fill engine is granted and streak resets to 0.
- In IDLE, CPU FB writes are always granted and streak stays 0.
- bus_stall is only ever asserted for FB writes. Register accesses never stall.
- Fill grant:
  - At the edge: mem_wren=1, mem_addr=cur_addr, mem_data=DATA.
  - cur_addr increments; FB_WORDS-1 wraps to 0.
  - remaining decrements.
  - When remaining was 1: RUN -> IDLE, fill_done pulses next cycle, the sticky bit is set.
- CPU grant: at the edge, mem_wren=1, mem_addr=bus_address[15:2], mem_data=bus_data_i.
- Idle cycle (no grant): mem_wren=0 at the edge; mem_addr and mem_data hold their values.
- Latency:
  - Every accepted write reaches mem_* exactly one cycle after its grant.
  - Go at edge N produces the first fill write on mem_* after edge N+1.
  - An uncontested fill of C words takes C cycles.
- Reset mid-RUN: immediately returns to IDLE with all outputs at 0. No done pulse is generated.

Test Plan:
1. Reset; write START=0, COUNT=4, DATA=32'hFFFFFFFF, CTRL=1 -> mem writes to addresses 0,1,2,3 on consecutive cycles with data FFFFFFFF; fill_done pulses once; a CTRL read returns 2, then 0 on the next read.
2. START=14998, COUNT=4, DATA=32'hA5A5A5A5 -> mem_addr sequence 14998, 14999, 0, 1.
3. COUNT=20 with continuous CPU FB writes during RUN -> 8 CPU grants, then 1 stall cycle carrying a fill write, repeating; no CPU write is lost or duplicated; all 20 fill words are written.
4. COUNT=0 with go -> fill_busy stays 0, no mem_wren, fill_done pulses one cycle after the CTRL write.
5. COUNT=100; abort via CTRL=2 after 10 fill writes -> at most 11 fill writes; fill_busy low the next cycle; fill_done pulses once.
6. Assert rst during RUN with COUNT=50 -> mem_wren, fill_busy and fill_done are 0 immediately. After release, a CPU FB write to byte address 24'h0010 appears one cycle later as mem_addr=4.
